mult_div_unit: RTL and testbench

Iterative, parametrised multiply/divide unit for the multicycle MIPS datapath. It is the next-generation replacement for the current unsigned shift-add multiplier that keys off the controller state. It performs signed/unsigned multiply and divide on WIDTH-bit operands with an explicit Start/Busy/Done handshake, and returns a 2·WIDTH result split into Hi/Lo for the register-bank write-back mux (mfhi/mflo paths).

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_unit                                                            |
// | Iterative signed/unsigned multiply (shift-add) and divide (restoring)    |
// | with Start/Busy/Done handshake; divider built only with                  |
// | MULT_DIV_UNIT_DIVIDE_EN defined.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Unsupported
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0]    c_st_idle = 2'd0;
  localparam logic [1:0]    c_st_calc = 2'd1;
  localparam logic [1:0]    c_st_fix  = 2'd2;
  localparam logic [1:0]    c_st_done = 2'd3;
  localparam logic [CW-1:0] c_last    = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div_zero;
  logic               r_unsup;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
  logic               r_is_div;
`endif

  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_calc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Op[0]=0 selects the signed variants; the datapath works on magnitudes.
  assign w_sign_a = ~Op[0] & A[WIDTH-1];
  assign w_sign_b = ~Op[0] & B[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -A : A;
  assign w_mag_b  = w_sign_b ? -B : B;

  // Multiplier sits in the low half and shifts out LSB-first.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

`ifdef MULT_DIV_UNIT_DIVIDE_EN
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Remainder in the high half, dividend shifts out of / quotient into the low half.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
  assign w_quo      = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign w_calc_next = r_is_div ? w_div_next : w_mul_next;
  assign w_fix_hi    = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo    = r_is_div ? w_quo : w_prod[WIDTH-1:0];
`else
  assign w_calc_next = w_mul_next;
  assign w_fix_hi    = w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo    = w_prod[WIDTH-1:0];
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= c_st_idle;
      r_cnt      <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
      r_unsup    <= 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
      r_is_div   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_st_calc: begin
          r_acc <= w_calc_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            r_state <= c_st_fix;
          end
        end
        c_st_fix: begin
          r_hi       <= w_fix_hi;
          r_lo       <= w_fix_lo;
          r_div_zero <= 1'b0;
          r_unsup    <= 1'b0;
          r_state    <= c_st_done;
        end
        default: begin
          // IDLE and DONE both accept a new request.
          r_state <= c_st_idle;
          if (Start) begin
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_opnd   <= w_mag_b;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
            r_cnt    <= '0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            r_is_div <= Op[1];
            if (Op[1] && (B == '0)) begin
              r_hi       <= A;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
              r_unsup    <= 1'b0;
              r_state    <= c_st_done;
            end else begin
              r_state <= c_st_calc;
            end
`else
            if (Op[1]) begin
              r_div_zero <= 1'b0;
              r_unsup    <= 1'b1;
              r_state    <= c_st_done;
            end else begin
              r_state <= c_st_calc;
            end
`endif
          end
        end
      endcase
    end
  end

  assign Hi          = r_hi;
  assign Lo          = r_lo;
  assign Busy        = (r_state == c_st_calc) || (r_state == c_st_fix);
  assign Done        = (r_state == c_st_done);
  assign DivZero     = r_div_zero;
  assign Unsupported = r_unsup;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_div_unit                                                         |
// | Directed-vector scoreboard bench for mult_div_unit (WIDTH=32).           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam int c_lat = WIDTH + 2;
  localparam logic [1:0] c_mult  = 2'b00;
  localparam logic [1:0] c_multu = 2'b01;
  localparam logic [1:0] c_div   = 2'b10;
  localparam logic [1:0] c_divu  = 2'b11;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic             Unsupported;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        un;
    int          done_cyc;
    int          busy;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          busy_cnt = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .A          (A),
    .B          (B),
    .Hi         (Hi),
    .Lo         (Lo),
    .Busy       (Busy),
    .Done       (Done),
    .DivZero    (DivZero),
    .Unsupported(Unsupported)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done is matched against the oldest scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        busy_cnt = 0;
      end else begin
        if (Busy) busy_cnt++;
        if (Done) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: Done=1 at cycle %0d, expected no completion", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("hi", {32'd0, Hi}, {32'd0, e.hi});
            chk("lo", {32'd0, Lo}, {32'd0, e.lo});
            chk("div_zero", {63'd0, DivZero}, {63'd0, e.dz});
            chk("unsupported", {63'd0, Unsupported}, {63'd0, e.un});
            chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Called at a falling edge; the following rising edge samples the request.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    e.hi = ehi;
    e.lo = elo;
    e.dz = edz;
    e.un = 1'b0;
    e.done_cyc = edz ? cyc + 1 : cyc + c_lat;
    e.busy     = edz ? 0 : WIDTH + 1;
`ifndef MULT_DIV_UNIT_DIVIDE_EN
    if (op[1]) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b0;
      e.un = 1'b1;
      e.done_cyc = cyc + 1;
      e.busy     = 0;
    end
`endif
    model_hi = e.hi;
    model_lo = e.lo;
    sb_q.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge Clk);
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge Clk);
    while (!Done && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (!Done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: Done=%0b, expected 1 within 200 cycles", Done);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hi"}, {32'd0, Hi}, 64'd0);
    chk({tag, "_lo"}, {32'd0, Lo}, 64'd0);
    chk({tag, "_busy"}, {63'd0, Busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, Done}, 64'd0);
    chk({tag, "_div_zero"}, {63'd0, DivZero}, 64'd0);
    chk({tag, "_unsupported"}, {63'd0, Unsupported}, 64'd0);
  endtask

  initial begin
    logic [1:0] rst_op;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = '0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk_reset_outputs("reset");

    issue(c_mult,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0); drain();
    issue(c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0); drain();
    issue(c_mult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0); drain();
    issue(c_mult,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0); drain();
    issue(c_div,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0); drain();
    issue(c_divu,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0); drain();
    issue(c_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0); drain();
    issue(c_div,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0); drain();
    issue(c_div,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0); drain();
    issue(c_divu,  32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, 1'b0); drain();
    issue(c_divu,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1'b1); drain();
    issue(c_multu, 32'd3,         32'd4,        32'd0,         32'd12,        1'b0); drain();

    // Start mid-operation must be ignored (a zero-divisor DIVU would otherwise finish at once).
    issue(c_multu, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
    repeat (9) @(negedge Clk);
    Start = 1'b1;
    Op    = c_divu;
    A     = 32'd5;
    B     = 32'd0;
    @(negedge Clk);
    Start = 1'b0;
    drain();

    // Back-to-back: new request issued in the DONE cycle.
    issue(c_mult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    wait_done();
    issue(c_multu, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    drain();

    // Reset at cycle 20 of an operation discards it.
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    rst_op = c_div;
`else
    rst_op = c_multu;
`endif
    Start = 1'b1;
    Op    = rst_op;
    A     = 32'hFFFF_FFF9;
    B     = 32'd2;
    @(negedge Clk);
    Start = 1'b0;
    repeat (19) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk_reset_outputs("mid_reset");
    model_hi = '0;
    model_lo = '0;
    repeat (40) @(negedge Clk);

    issue(c_multu, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0); drain();
    issue(c_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
